gw_par2ser_shifter: RTL and testbench

//  Parallel-to-serial shifter feeding the single-bit D input of a downstream

---
 rtl/gw_par2ser_shifter_pkg.sv | 17 +
 rtl/gw_ser_bitcnt.sv | 36 +++
 rtl/gw_par2ser_shifter.sv | 125 ++++++++++++
 tb/tb_gw_par2ser_shifter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gw_par2ser_shifter_pkg.sv
// Shared types for the serializer family.
// Holds the FSM encoding and the legal WIDTH range.
package gw_par2ser_shifter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_st_e;

  localparam int SER_W_MIN = 2;
  localparam int SER_W_MAX = 32;

  function automatic bit ser_width_ok(input int w);
    return (w >= SER_W_MIN) && (w <= SER_W_MAX);
  endfunction

endpackage

// File: rtl/gw_ser_bitcnt.sv
// Modulo-WIDTH bit counter with enable, sync clear and
// terminal-count flag; shared with the deserializer.
module gw_ser_bitcnt #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     tc
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  // Count enabled cycles, wrapping after WIDTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (ce) begin
      if (clr) begin
        r_cnt <= '0;
      end else if (inc) begin
        r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign cnt = r_cnt;
  assign tc  = (r_cnt == LAST_CNT);

endmodule

// File: rtl/gw_par2ser_shifter.sv
// Parallel-to-serial shifter driving a single-bit output flop.
// Words stream back-to-back; Q rests at IDLE_VAL between words.
module gw_par2ser_shifter
  import gw_par2ser_shifter_pkg::*;
#(
  parameter int   WIDTH     = 4,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic IDLE_VAL  = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CE,
  input  logic             LOAD_VLD,
  output logic             LOAD_RDY,
  input  logic [WIDTH-1:0] D,
  output logic             Q,
  output logic             BUSY,
  output logic             LAST
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] PEN_CNT = CW'(WIDTH - 2);

  if (!ser_width_ok(WIDTH)) begin : g_width_chk
    $error("gw_par2ser_shifter: WIDTH must be 2..32");
  end

  ser_st_e          r_st;
  logic             r_q;
  logic             r_busy;
  logic             r_last;
  logic [WIDTH-1:0] r_sreg;

  ser_st_e          w_st_nxt;
  logic             w_q_nxt;
  logic             w_busy_nxt;
  logic             w_last_nxt;
  logic [WIDTH-1:0] w_sreg_nxt;

  logic             w_acc;
  logic             w_clr;
  logic             w_inc;
  logic             w_tc;
  logic [CW-1:0]    w_cnt;
  logic             w_first;
  logic [WIDTH-1:0] w_rest;
  logic             w_next;
  logic [WIDTH-1:0] w_shift;

  gw_ser_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk   (CLK),
    .rst_n (RESETN),
    .ce    (CE),
    .clr   (w_clr),
    .inc   (w_inc),
    .cnt   (w_cnt),
    .tc    (w_tc)
  );

  // Ready when idle or when the final bit is on Q.
  assign LOAD_RDY = CE & ((r_st == ST_IDLE) |
                          ((r_st == ST_SHIFT) & w_tc));
  assign w_acc    = LOAD_VLD & LOAD_RDY;

  assign w_first  = LSB_FIRST ? D[0] : D[WIDTH-1];
  assign w_rest   = LSB_FIRST ? (D >> 1) : (D << 1);
  assign w_next   = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];
  assign w_shift  = LSB_FIRST ? (r_sreg >> 1) : (r_sreg << 1);

  // Next-state and next-output selection.
  always_comb begin
    w_st_nxt   = r_st;
    w_q_nxt    = r_q;
    w_busy_nxt = r_busy;
    w_last_nxt = r_last;
    w_sreg_nxt = r_sreg;
    w_clr      = 1'b0;
    w_inc      = 1'b0;
    if (w_acc) begin
      w_st_nxt   = ST_SHIFT;
      w_q_nxt    = w_first;
      w_sreg_nxt = w_rest;
      w_busy_nxt = 1'b1;
      w_last_nxt = 1'b0;
      w_clr      = 1'b1;
    end else if (r_st == ST_SHIFT) begin
      if (!w_tc) begin
        w_q_nxt    = w_next;
        w_sreg_nxt = w_shift;
        w_last_nxt = (w_cnt == PEN_CNT);
        w_inc      = 1'b1;
      end else begin
        w_st_nxt   = ST_IDLE;
        w_q_nxt    = IDLE_VAL;
        w_busy_nxt = 1'b0;
        w_last_nxt = 1'b0;
        w_clr      = 1'b1;
      end
    end
  end

  // State and output flops; everything holds while CE is low.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_st   <= ST_IDLE;
      r_q    <= IDLE_VAL;
      r_busy <= 1'b0;
      r_last <= 1'b0;
      r_sreg <= '0;
    end else if (CE) begin
      r_st   <= w_st_nxt;
      r_q    <= w_q_nxt;
      r_busy <= w_busy_nxt;
      r_last <= w_last_nxt;
      r_sreg <= w_sreg_nxt;
    end
  end

  assign Q    = r_q;
  assign BUSY = r_busy;
  assign LAST = r_last;

endmodule

// File: tb/tb_gw_par2ser_shifter.sv
// Scoreboard bench for gw_par2ser_shifter.
// Two instances: 4-bit LSB-first and 8-bit MSB-first.
module tb_gw_par2ser_shifter;

  typedef struct packed {
    logic q;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ce = 1'b1;
  logic       a_vld = 1'b0;
  logic [3:0] a_d = '0;
  logic       b_vld = 1'b0;
  logic [7:0] b_d = '0;

  logic a_rdy, a_q, a_busy, a_last;
  logic b_rdy, b_q, b_busy, b_last;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  gw_par2ser_shifter #(
    .WIDTH(4), .LSB_FIRST(1'b1), .IDLE_VAL(1'b1)
  ) u_dut_a (
    .CLK(clk), .RESETN(rstn), .CE(ce),
    .LOAD_VLD(a_vld), .LOAD_RDY(a_rdy), .D(a_d),
    .Q(a_q), .BUSY(a_busy), .LAST(a_last)
  );

  gw_par2ser_shifter #(
    .WIDTH(8), .LSB_FIRST(1'b0), .IDLE_VAL(1'b1)
  ) u_dut_b (
    .CLK(clk), .RESETN(rstn), .CE(ce),
    .LOAD_VLD(b_vld), .LOAD_RDY(b_rdy), .D(b_d),
    .Q(b_q), .BUSY(b_busy), .LAST(b_last)
  );

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit to_b, input logic [31:0] d,
                      input int w, input bit lsb);
    for (int i = 0; i < w; i++) begin
      exp_t e;
      int   idx;
      idx    = lsb ? i : w - 1 - i;
      e.q    = d[idx];
      e.last = (i == w - 1);
      if (to_b) exp_b.push_back(e);
      else      exp_a.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept.
  task automatic send_a(input logic [3:0] d);
    int n;
    n = 0;
    a_vld = 1'b1;
    a_d   = d;
    while (!a_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("A_accept_wait", a_rdy, 1'b1);
    push(1'b0, 32'(d), 4, 1'b1);
    @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] d);
    int n;
    n = 0;
    b_vld = 1'b1;
    b_d   = d;
    while (!b_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("B_accept_wait", b_rdy, 1'b1);
    push(1'b1, 32'(d), 8, 1'b0);
    @(negedge clk);
  endtask

  always @(posedge clk) begin : mon_a
    logic ce_s;
    exp_t e;
    ce_s = ce;
    #1;
    if (mon_en && ce_s) begin
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        chk("A_busy", a_busy, 1'b1);
        chk("A_q", a_q, e.q);
        chk("A_last", a_last, e.last);
      end else begin
        chk("A_idle_busy", a_busy, 1'b0);
        chk("A_idle_q", a_q, 1'b1);
        chk("A_idle_last", a_last, 1'b0);
      end
    end
  end

  always @(posedge clk) begin : mon_b
    logic ce_s;
    exp_t e;
    ce_s = ce;
    #1;
    if (mon_en && ce_s) begin
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        chk("B_busy", b_busy, 1'b1);
        chk("B_q", b_q, e.q);
        chk("B_last", b_last, e.last);
      end else begin
        chk("B_idle_busy", b_busy, 1'b0);
        chk("B_idle_q", b_q, 1'b1);
        chk("B_idle_last", b_last, 1'b0);
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("RST_A_q", a_q, 1'b1);
    chk("RST_A_busy", a_busy, 1'b0);
    chk("RST_A_last", a_last, 1'b0);
    chk("RST_A_rdy", a_rdy, 1'b1);
    chk("RST_B_q", b_q, 1'b1);
    chk("RST_B_busy", b_busy, 1'b0);
    rstn   = 1'b1;
    mon_en = 1'b1;

    // Idle after reset release.
    repeat (10) begin
      @(negedge clk);
      chk("T1_rdy", a_rdy, 1'b1);
    end

    // Single word.
    send_a(4'b0110);
    a_vld = 1'b0;
    chk("T2_rdy_midword", a_rdy, 1'b0);
    repeat (6) @(negedge clk);

    // Back-to-back, valid held high.
    send_a(4'hA);
    send_a(4'h5);
    a_vld = 1'b0;
    repeat (6) @(negedge clk);

    // Clock enable low mid-word, after bit 1.
    send_a(4'hC);
    a_vld = 1'b0;
    @(negedge clk);
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("T4_q_frozen", a_q, 1'b0);
      chk("T4_busy_frozen", a_busy, 1'b1);
      chk("T4_rdy_a", a_rdy, 1'b0);
      chk("T4_rdy_b_idle", b_rdy, 1'b0);
    end
    ce = 1'b1;
    repeat (6) @(negedge clk);

    // Async reset mid-word.
    send_a(4'h9);
    a_vld = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("T5_q", a_q, 1'b1);
    chk("T5_busy", a_busy, 1'b0);
    chk("T5_last", a_last, 1'b0);
    chk("T5_rdy", a_rdy, 1'b1);
    exp_a.delete();
    exp_b.delete();
    #1 rstn = 1'b1;
    @(negedge clk);
    send_a(4'h6);
    a_vld = 1'b0;
    repeat (6) @(negedge clk);

    // MSB-first 8-bit word, valid toggled while busy.
    send_b(8'h81);
    b_d = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      b_vld = (i % 2 == 0);
      chk("T6_rdy_low", b_rdy, 1'b0);
      @(negedge clk);
    end
    b_vld = 1'b0;
    repeat (6) @(negedge clk);

    n = 0;
    while ((exp_a.size() + exp_b.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (exp_a.size() + exp_b.size()) == 0, 1'b1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
